// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO read-side output stage.
package fifo_pkg;

    // RAM read latency in read-clock cycles: a pop in cycle N returns data in N+1.
    localparam int FIFO_RD_LAT = 1;

    // Output buffer depth; two entries cover the pop-to-data round trip at full rate.
    localparam int FWFT_SKID_D = 2;

    // Occupancy of the output buffer, 0..FWFT_SKID_D.
    typedef logic [1:0] cnt_t;

endpackage : fifo_pkg

// File: rtl/fwft_skid_buf.sv
// Two-entry register queue feeding the first-word-fall-through output.
// Entry 0 is always the head; entry 1 holds the second word when two are buffered.
module fwft_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_rclk,
    input  logic              i_rrst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        cnt
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    cnt_t              cnt_q;
    logic              do_rd;

    // A read of an empty queue is ignored so the count can never underflow.
    assign do_rd = rd_en && (cnt_q != 2'd0);

    // Queue update: write goes to the first free slot, read shifts entry 1 into the head.
    always_ff @(posedge i_rclk) begin
        if (!i_rrst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            cnt_q <= '0;
        end else begin
            unique case ({wr_en, do_rd})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        ent0 <= wr_data;
                    end else begin
                        ent1 <= wr_data;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (cnt_q == 2'd1) begin
                        ent0 <= wr_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= wr_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head = ent0;
    assign cnt  = cnt_q;

endmodule : fwft_skid_buf

// File: rtl/rd_fwft_stage.sv
// Read-side FWFT output stage of the async FIFO.
// Issues pops against a credit count so that every word returned by the RAM
// has a buffer slot, and presents the buffered head as a valid/ready stream.
// Note: o_rinc is combinational from i_ready and i_empty (through deq and the
// credit compare); the consumer must not derive i_ready from o_rinc.
module rd_fwft_stage
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_rclk,
    input  logic              i_rrst_n,
    input  logic              i_empty,
    output logic              o_rinc,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    localparam int SKID_D = FWFT_SKID_D;

    logic              warm;
    logic              inflight;
    logic              pop;
    logic              deq;
    logic [1:0]        buf_cnt;
    logic [DATA_W-1:0] head;
    logic [2:0]        credit_sum;

    // Warm-up and pop-tracking: empty flag is untrusted in the first cycle after reset.
    always_ff @(posedge i_rclk) begin
        if (!i_rrst_n) begin
            warm     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            warm     <= 1'b1;
            inflight <= pop;
        end
    end

    assign o_valid = (buf_cnt != 2'd0);
    assign o_data  = head;
    assign deq     = o_valid & i_ready;

    // Words owned by this stage after this cycle's dequeue: buffered plus in flight.
    assign credit_sum = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, deq};
    assign o_rinc     = warm & ~i_empty & (credit_sum < 3'(SKID_D));
    assign pop        = o_rinc & ~i_empty;

    fwft_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_rclk   (i_rclk),
        .i_rrst_n (i_rrst_n),
        .wr_en    (inflight),
        .wr_data  (i_rdata),
        .rd_en    (deq),
        .head     (head),
        .cnt      (buf_cnt)
    );

    // Credit logic must never let a returning word arrive at a full buffer.
    always_ff @(posedge i_rclk) begin
        if (i_rrst_n) begin
            assert (!(inflight && (buf_cnt == 2'(SKID_D))))
                else $error("rd_fwft_stage: write into full output buffer");
        end
    end

endmodule : rd_fwft_stage
